// File: rtl/picomips_sw_driver.sv
// picomips_sw_driver
// Drives a picoMIPS core through its switch/LED pins. One signed (x, y) pair
// is taken from a ready/valid host port, shown to the core on SW[7:0] with
// handshakes on SW[8], and the two signed results the core puts on LED are
// captured and returned with a one-cycle out_valid pulse.
//
// Parameters
//   HOLD_CYCLES  cycles each SW[8] level is held (32..255)
//   BOOT_CYCLES  cycles SW[9] (core run / active-low core reset) stays low
//                after nReset is released (1..15)
// Ports
//   Clock        rising-edge clock
//   nReset       asynchronous active-low reset
//   in_valid     host offers (in_x, in_y)
//   in_ready     block accepts a pair this cycle (high only when idle)
//   in_x, in_y   signed 8-bit input coordinates
//   SW[9:0]      [9] core run, [8] strobe, [7:0] data to the core
//   LED[7:0]     signed result bus from the core
//   out_valid    one-cycle pulse, out_x2/out_y2 freshly captured
//   out_x2/y2    captured signed results, held until the next capture
`timescale 1ns/1ps
module picomips_sw_driver #(
    parameter int unsigned HOLD_CYCLES = 40,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [7:0] in_y,
    output logic [9:0] SW,
    input  logic [7:0] LED,
    output logic       out_valid,
    output logic [7:0] out_x2,
    output logic [7:0] out_y2
);

    localparam logic [3:0] ST_BOOT    = 4'd0;
    localparam logic [3:0] ST_IDLE    = 4'd1;
    localparam logic [3:0] ST_X_SETUP = 4'd2;
    localparam logic [3:0] ST_X_HI    = 4'd3;
    localparam logic [3:0] ST_X_LO    = 4'd4;
    localparam logic [3:0] ST_Y_SETUP = 4'd5;
    localparam logic [3:0] ST_Y_HI    = 4'd6;
    localparam logic [3:0] ST_Y_LO    = 4'd7;
    localparam logic [3:0] ST_R_HI    = 4'd8;
    localparam logic [3:0] ST_R_LO    = 4'd9;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic [7:0] data_q, data_d;
    logic       strobe_q, strobe_d;
    logic       run_q, run_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] x2_q, x2_d;
    logic [7:0] y2_q, y2_d;
    logic       phase_done_s;
    logic [7:0] cnt_dec_s;

    // A hold phase ends once the down-counter has reached zero; it never wraps.
    assign phase_done_s = (cnt_q == 8'd0);
    assign cnt_dec_s    = phase_done_s ? 8'd0 : (cnt_q - 8'd1);

    // Next-state logic. Output registers are computed from the state being
    // entered so that every output is a flop with no input-to-output path.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        data_d      = data_q;
        strobe_d    = strobe_q;
        run_d       = run_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        x2_d        = x2_q;
        y2_d        = y2_q;
        case (state_q)
            ST_BOOT: begin
                // The boot counter counts up from the reset value of zero.
                if (cnt_q == BOOT_LAST) begin
                    state_d    = ST_IDLE;
                    cnt_d      = 8'd0;
                    run_d      = 1'b1;
                    in_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d  = ST_X_SETUP;
                    data_d   = in_x;
                    y_d      = in_y;
                    strobe_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_X_SETUP: begin
                state_d  = ST_X_HI;
                cnt_d    = HOLD_LOAD;
                strobe_d = 1'b1;
            end
            ST_X_HI: begin
                if (phase_done_s) begin
                    state_d  = ST_X_LO;
                    cnt_d    = HOLD_LOAD;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            ST_X_LO: begin
                if (phase_done_s) begin
                    state_d = ST_Y_SETUP;
                    data_d  = y_q;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            ST_Y_SETUP: begin
                state_d  = ST_Y_HI;
                cnt_d    = HOLD_LOAD;
                strobe_d = 1'b1;
            end
            ST_Y_HI: begin
                if (phase_done_s) begin
                    state_d  = ST_Y_LO;
                    cnt_d    = HOLD_LOAD;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            ST_Y_LO: begin
                // The core shows x2 by the end of this phase.
                if (phase_done_s) begin
                    state_d  = ST_R_HI;
                    cnt_d    = HOLD_LOAD;
                    strobe_d = 1'b1;
                    x2_d     = LED;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            ST_R_HI: begin
                // The core shows y2 while the result strobe is high.
                if (phase_done_s) begin
                    state_d  = ST_R_LO;
                    cnt_d    = HOLD_LOAD;
                    strobe_d = 1'b0;
                    y2_d     = LED;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            ST_R_LO: begin
                if (phase_done_s) begin
                    state_d     = ST_IDLE;
                    cnt_d       = 8'd0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec_s;
                end
            end
            default: begin
                state_d  = ST_BOOT;
                cnt_d    = 8'd0;
                run_d    = 1'b0;
                strobe_d = 1'b0;
                data_d   = 8'd0;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_BOOT;
            cnt_q       <= 8'd0;
            y_q         <= 8'd0;
            data_q      <= 8'd0;
            strobe_q    <= 1'b0;
            run_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            x2_q        <= 8'd0;
            y2_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            run_q       <= run_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
        end
    end

    assign SW        = {run_q, strobe_q, data_q};
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x2    = x2_q;
    assign out_y2    = y2_q;

endmodule

// File: tb/tb_picomips_sw_driver.sv
// Self-checking bench for picomips_sw_driver with a behavioural picoMIPS core
// model on SW/LED. The core computes the affine map
//   x2 = (3x + 2y)/4 + 20,   y2 = (-2x + 3y)/4 - 20   (floor division)
// which yields (40,20)->(60,-25), (-40,0)->(-10,0), (0,0)->(20,-20).
`timescale 1ns/1ps
module tb_picomips_sw_driver;

    localparam int H = 40;
    localparam int B = 4;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic [9:0] SW;
    logic [7:0] LED;
    logic       out_valid;
    logic [7:0] out_x2;
    logic [7:0] out_y2;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    picomips_sw_driver #(.HOLD_CYCLES(H), .BOOT_CYCLES(B)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .SW       (SW),
        .LED      (LED),
        .out_valid(out_valid),
        .out_x2   (out_x2),
        .out_y2   (out_y2)
    );

    function automatic logic [7:0] core_x2(input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        int r;
        xi = int'($signed(x));
        yi = int'($signed(y));
        r  = ((3 * xi + 2 * yi) >>> 2) + 20;
        return r[7:0];
    endfunction

    function automatic logic [7:0] core_y2(input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        int r;
        xi = int'($signed(x));
        yi = int'($signed(y));
        r  = ((-2 * xi + 3 * yi) >>> 2) - 20;
        return r[7:0];
    endfunction

    // Expected SW k cycles after the accepting edge, from the phase schedule.
    function automatic logic [9:0] exp_sw(input int k, input logic [7:0] x, input logic [7:0] y);
        if (k == 0)              return {2'b10, x};
        else if (k <= H)         return {2'b11, x};
        else if (k <= 2 * H)     return {2'b10, x};
        else if (k == 2 * H + 1) return {2'b10, y};
        else if (k <= 3 * H + 1) return {2'b11, y};
        else if (k <= 4 * H + 1) return {2'b10, y};
        else if (k <= 5 * H + 1) return {2'b11, y};
        else                     return {2'b10, y};
    endfunction

    // Core model: latch data on strobe rises; show x2 after the y strobe,
    // y2 after the result strobe, and junk after the x strobe.
    logic       prev_strobe;
    logic [1:0] slot;
    logic [7:0] cx;
    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            prev_strobe <= 1'b0;
            slot        <= 2'd0;
            cx          <= 8'd0;
            LED         <= 8'd0;
        end else begin
            prev_strobe <= SW[8];
            if (SW[8] && !prev_strobe) begin
                case (slot)
                    2'd0: begin cx <= SW[7:0]; LED <= 8'($urandom); slot <= 2'd1; end
                    2'd1: begin LED <= core_x2(cx, SW[7:0]); slot <= 2'd2; end
                    default: begin LED <= core_y2(cx, SW[7:0]); slot <= 2'd0; end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic release_boot();
        int bad;
        bad = 0;
        @(negedge Clock);
        nReset = 1'b1;
        for (int e = 1; e <= B; e++) begin
            @(negedge Clock);
            if (e < B && (SW !== 10'h000 || in_ready !== 1'b0)) bad++;
        end
        check("boot_hold_low", bad, 0);
        check("boot_sw", SW, 10'h200);
        check("boot_ready", in_ready, 1);
    endtask

    task automatic assert_reset();
        @(negedge Clock);
        nReset   = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_sw", SW, 10'h000);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_x2", out_x2, 8'h00);
        check("rst_y2", out_y2, 8'h00);
    endtask

    // One transaction. Called just after a negedge; returns at the out_valid
    // negedge when keep_valid is set, else one cycle later.
    task automatic txn(input logic [7:0] x, input logic [7:0] y, input int pulse_k,
                       input int abort_k, input bit keep_valid,
                       input logic [7:0] nx, input logic [7:0] ny, output bit ov_at_accept);
        int w;
        int k;
        int lat;
        int bad_sw;
        int bad_rdy;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 1000) begin
            @(negedge Clock);
            w++;
        end
        check("accept_ready", in_ready, 1);
        ov_at_accept = out_valid;
        @(posedge Clock);
        @(negedge Clock);
        if (keep_valid) begin
            in_x = nx;
            in_y = ny;
        end else begin
            in_valid = 1'b0;
        end
        k = 0; lat = -1; bad_sw = 0; bad_rdy = 0;
        while (k <= 2000) begin
            if (k == abort_k) begin
                nReset   = 1'b0;
                in_valid = 1'b0;
                #1;
                check("abort_sw", SW, 10'h000);
                check("abort_valid", out_valid, 0);
                check("abort_ready", in_ready, 0);
                check("abort_x2", out_x2, 8'h00);
                check("abort_y2", out_y2, 8'h00);
                return;
            end
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (SW !== exp_sw(k, x, y)) bad_sw++;
            if (in_ready !== 1'b0) bad_rdy++;
            if (k == pulse_k) begin
                in_x = ~x;
                in_valid = 1'b1;
            end else if (k == pulse_k + 1) begin
                in_x = x;
                in_valid = 1'b0;
            end
            @(negedge Clock);
            k++;
        end
        check("sw_sequence", bad_sw, 0);
        check("busy_not_ready", bad_rdy, 0);
        check("latency", lat, 6 * H + 2);
        check("x2", out_x2, core_x2(x, y));
        check("y2", out_y2, core_y2(x, y));
        check("ready_with_valid", in_ready, 1);
        check("sw_hold_y", SW, {2'b10, y});
        if (!keep_valid) begin
            @(negedge Clock);
            check("valid_one_cycle", out_valid, 0);
            check("x2_held", out_x2, core_x2(x, y));
        end
    endtask

    initial begin
        bit ov;
        int cnt;
        logic [7:0] rx;
        logic [7:0] ry;
        nReset = 1'b1; in_valid = 1'b0; in_x = 8'h00; in_y = 8'h00;

        // Reset, then release: SW[9] low for B cycles, ready on the next.
        assert_reset();
        @(negedge Clock);
        release_boot();

        // Directed pairs with known core results.
        txn(8'd40, 8'd20, -1, -1, 1'b0, 8'h00, 8'h00, ov);
        check("dir_40_20_x2", out_x2, 8'h3C);
        check("dir_40_20_y2", out_y2, 8'hE7);
        txn(8'hD8, 8'h00, -1, -1, 1'b0, 8'h00, 8'h00, ov);
        check("dir_m40_0_x2", out_x2, 8'hF6);
        check("dir_m40_0_y2", out_y2, 8'h00);

        // in_valid held high across two pairs: second accepted on out_valid.
        txn(8'd40, 8'd20, -1, -1, 1'b1, 8'h00, 8'h00, ov);
        txn(8'h00, 8'h00, -1, -1, 1'b0, 8'h00, 8'h00, ov);
        check("b2b_accept_on_valid", ov, 1);
        check("b2b_x2", out_x2, 8'h14);
        check("b2b_y2", out_y2, 8'hEC);

        // in_valid pulse during X_HI must be ignored.
        txn(8'h11, 8'h22, 10, -1, 1'b0, 8'h00, 8'h00, ov);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b1 || out_valid !== 1'b0) cnt++;
            @(negedge Clock);
        end
        check("pulse_no_extra_txn", cnt, 0);

        // Randomized pairs.
        for (int t = 0; t < 6; t++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            txn(rx, ry, -1, -1, 1'b0, 8'h00, 8'h00, ov);
        end

        // Reset during Y_HI: outputs clear at once, no result, boot restarts.
        rx = 8'($urandom);
        ry = 8'($urandom);
        txn(rx, ry, -1, 2 * H + 10, 1'b0, 8'h00, 8'h00, ov);
        @(negedge Clock);
        release_boot();
        cnt = 0;
        for (int i = 0; i < 7 * H; i++) begin
            if (out_valid !== 1'b0) cnt++;
            @(negedge Clock);
        end
        check("no_valid_after_abort", cnt, 0);

        // Recovery after the aborted transaction.
        txn(8'd40, 8'd20, -1, -1, 1'b0, 8'h00, 8'h00, ov);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
